// File: rtl/booth_mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth digit encoding, bit order {neg, one, two}
  localparam logic [2:0] ZERO = 3'b000;
  localparam logic [2:0] POS1 = 3'b010;
  localparam logic [2:0] POS2 = 3'b001;
  localparam logic [2:0] NEG1 = 3'b110;
  localparam logic [2:0] NEG2 = 3'b101;

  function automatic int unsigned iter_count(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Operand/result handshake bundle for booth_mul_seq.
interface booth_mul_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {neg, one, two} digit controls.
module booth_r4_recoder
  import booth_mul_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       one,
  output logic       two
);

  logic [2:0] digit_c;

  always_comb begin
    digit_c = ZERO;
    case (window)
      3'b001, 3'b010: digit_c = POS1;
      3'b011:         digit_c = POS2;
      3'b100:         digit_c = NEG2;
      3'b101, 3'b110: digit_c = NEG1;
      default:        digit_c = ZERO;
    endcase
    {neg, one, two} = digit_c;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, valid/ready on both sides.
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  booth_mul_seq_if.slave bus
);

  localparam int unsigned XW   = WIDTH + 2;
  localparam int unsigned AW   = 2 * WIDTH + 4;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned ITER = iter_count(WIDTH);
  localparam int unsigned CW   = $clog2(ITER);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // multiplicand, pre-shifted to the weight of the current digit
  logic [AW-1:0]   a_q, a_d;
  // extended multiplier with appended Booth LSB, shifted right two bits per digit
  logic [XW:0]     b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q, product_d;
  logic            out_valid_q, out_valid_d;

  logic            in_ready_c, accept_c;
  logic            a_sign_c, b_sign_c;
  logic            neg_c, one_c, two_c;
  logic [AW-1:0]   mag_c, pp_c, acc_sum_c;

  booth_r4_recoder u_recoder (
    .window (b_q[2:0]),
    .neg    (neg_c),
    .one    (one_c),
    .two    (two_c)
  );

  assign in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign a_sign_c   = bus.is_signed & bus.a[WIDTH-1];
  assign b_sign_c   = bus.is_signed & bus.b[WIDTH-1];

  // Partial product and accumulate; wraps mod 2^AW, exact in the low PW bits
  always_comb begin
    mag_c = '0;
    if (two_c)      mag_c = a_q << 1;
    else if (one_c) mag_c = a_q;
    pp_c      = neg_c ? (~mag_c + AW'(1)) : mag_c;
    acc_sum_c = acc_q + pp_c;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: ;
      BUSY: begin
        acc_d = acc_sum_c;
        a_d   = a_q << 2;
        b_d   = b_q >> 2;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d     = DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          product_d   = acc_sum_c[PW-1:0];
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture overrides IDLE/DONE handling; also covers the back-to-back DONE->BUSY case
    if (accept_c) begin
      state_d = BUSY;
      cnt_d   = '0;
      acc_d   = '0;
      a_d     = {{(AW - WIDTH){a_sign_c}}, bus.a};
      b_d     = {{2{b_sign_c}}, bus.b, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomised checks of booth_mul_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mul_seq_if #(.WIDTH(32)) bus ();
  booth_mul_seq_if #(.WIDTH(8))  bus8 ();

  booth_mul_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Drive one 32-bit operation, return product and cycles from accept edge to out_valid
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                        output logic [63:0] p, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.is_signed = sv; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = 32'h0; bus.b = 32'h0; bus.is_signed = ~sv;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus.product;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.product !== 64'h0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_w32: out_valid=%b product=%h in_ready=%b, want 0/0/1",
               bus.out_valid, bus.product, bus.in_ready);
    end
    n_cmp++;
    if (bus8.out_valid !== 1'b0 || bus8.product !== 16'h0 || bus8.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_w8: out_valid=%b product=%h in_ready=%b, want 0/0/1",
               bus8.out_valid, bus8.product, bus8.in_ready);
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [4] = '{32'd15, 32'hFFFF_FFE0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] vb [4] = '{32'd16, 32'hFFFF_FFFB, 32'd10, 32'hFFFF_FFF9};
    logic [63:0] ve [4] = '{64'd240, 64'd160, 64'hFFFF_FFFF_FFFF_FFF6, 64'd0};
    logic [63:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 1'b1, p, lat);
      n_cmp++;
      if (p !== ve[i]) begin
        n_err++;
        $display("FAIL signed_%0d product: got %h want %h", i, p, ve[i]);
      end
      n_cmp++;
      if (lat != 17) begin
        n_err++;
        $display("FAIL signed_%0d latency: got %0d want 17", i, lat);
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL drop_after_accept: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_unsigned_extremes();
    logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb [4] = '{32'd2, 32'd2, 32'h8000_0000, 32'hFFFF_FFFF};
    logic        vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] ve [4] = '{64'h0000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
                            64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001};
    logic [63:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], p, lat);
      n_cmp++;
      if (p !== ve[i] || lat != 17) begin
        n_err++;
        $display("FAIL mode_extreme_%0d: got %h lat %0d, want %h lat 17", i, p, lat, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    @(negedge clk);
    bus.a = 32'd7; bus.b = 32'd6; bus.is_signed = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat != 17 || bus.product !== 64'd42) begin
      n_err++;
      $display("FAIL bp_first: got %h lat %0d, want 42 lat 17", bus.product, lat);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.product !== 64'd42 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0 (product=%h out_valid=%b in_ready=%b)",
               bad, bus.product, bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.a = 32'hFFFF_FFFD; bus.b = 32'd5; bus.is_signed = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_in_ready_comb: got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: out_valid=%b in_ready=%b want 0/0", bus.out_valid, bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat != 17 || bus.product !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      n_err++;
      $display("FAIL b2b_result: got %h lat %0d, want fffffffffffffff1 lat 17", bus.product, lat);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] p;
    int lat;
    @(negedge clk);
    bus.a = 32'd100; bus.b = 32'd100; bus.is_signed = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.product !== 64'h0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: out_valid=%b product=%h in_ready=%b want 0/0/1",
               bus.out_valid, bus.product, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) lat++;
    end
    n_cmp++;
    if (lat != 0) begin
      n_err++;
      $display("FAIL mid_reset_no_output: out_valid seen %0d cycles, want 0", lat);
    end
    run_op(32'd3, 32'hFFFF_FFFC, 1'b1, p, lat);
    n_cmp++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFF4 || lat != 17) begin
      n_err++;
      $display("FAIL after_reset: got %h lat %0d, want fffffffffffffff4 lat 17", p, lat);
    end
  endtask

  task automatic test_random_w32();
    logic [31:0] av, bv;
    logic sv;
    logic signed [63:0] la, lb;
    logic [63:0] e, p;
    int lat;
    for (int k = 0; k < 100; k++) begin
      av = $urandom; bv = $urandom; sv = 1'($urandom);
      la = $signed(av); lb = $signed(bv);
      e  = sv ? 64'(la * lb) : ({32'h0, av} * {32'h0, bv});
      run_op(av, bv, sv, p, lat);
      n_cmp++;
      if (p !== e || lat != 17) begin
        n_err++;
        $display("FAIL rand32_%0d: %h*%h s=%b got %h lat %0d want %h lat 17", k, av, bv, sv, p, lat, e);
      end
    end
  endtask

  task automatic test_random_w8();
    logic [7:0] av, bv;
    logic sv;
    logic signed [15:0] sa, sb;
    logic [15:0] e, p;
    int lat, guard;
    for (int k = 0; k < 300; k++) begin
      av = 8'($urandom); bv = 8'($urandom); sv = 1'($urandom);
      sa = $signed(av); sb = $signed(bv);
      e  = sv ? 16'(sa * sb) : ({8'h0, av} * {8'h0, bv});
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      bus8.a = av; bus8.b = bv; bus8.is_signed = sv; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
      guard = 0;
      while (!bus8.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk); #1;
      bus8.in_valid = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.is_signed = ~sv;
      lat = 0;
      while (!bus8.out_valid && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      p = bus8.product;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      n_cmp++;
      if (p !== e || lat != 5) begin
        n_err++;
        $display("FAIL rand8_%0d: %h*%h s=%b got %h lat %0d want %h lat 5", k, av, bv, sv, p, lat, e);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0; bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0; bus8.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_signed();
    test_unsigned_extremes();
    test_back_to_back();
    test_reset_mid_op();
    test_random_w32();
    test_random_w8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
